// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline.
//   ctrl_t    : decode control bundle carried from D into E
//   CTRL_NOP  : all-zero control bundle used for bubbles and reset
//   RES_*     : ResultSrc encodings (ALU result, memory load data, PC+4)
package pipeline_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
        logic       JalrmuxSel;
    } ctrl_t;

    localparam ctrl_t      CTRL_NOP = '0;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_MEM  = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> Execute bus.
//   *_d : decode-slot instruction (control bundle, operands, PC info, indices, valid)
//   *_e : execute-slot copy registered by id_ex_stage
// Modports:
//   master : decode side, drives *_d and observes *_e
//   slave  : the ID/EX register, consumes *_d and drives *_e
interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RADDR_W    = 5
) ();
    import pipeline_pkg::*;

    ctrl_t                  ctrl_d;
    logic [DATA_WIDTH-1:0]  rd1_d;
    logic [DATA_WIDTH-1:0]  rd2_d;
    logic [DATA_WIDTH-1:0]  pc_d;
    logic [DATA_WIDTH-1:0]  pcplus4_d;
    logic [DATA_WIDTH-1:0]  immext_d;
    logic [2:0]             funct3_d;
    logic [RADDR_W-1:0]     rs1_d;
    logic [RADDR_W-1:0]     rs2_d;
    logic [RADDR_W-1:0]     rd_d;
    logic                   valid_d;

    ctrl_t                  ctrl_e;
    logic [DATA_WIDTH-1:0]  rd1_e;
    logic [DATA_WIDTH-1:0]  rd2_e;
    logic [DATA_WIDTH-1:0]  pc_e;
    logic [DATA_WIDTH-1:0]  pcplus4_e;
    logic [DATA_WIDTH-1:0]  immext_e;
    logic [2:0]             funct3_e;
    logic [RADDR_W-1:0]     rs1_e;
    logic [RADDR_W-1:0]     rs2_e;
    logic [RADDR_W-1:0]     rd_e;
    logic                   valid_e;

    modport master (
        output ctrl_d, rd1_d, rd2_d, pc_d, pcplus4_d, immext_d, funct3_d,
               rs1_d, rs2_d, rd_d, valid_d,
        input  ctrl_e, rd1_e, rd2_e, pc_e, pcplus4_e, immext_e, funct3_e,
               rs1_e, rs2_e, rd_e, valid_e
    );

    modport slave (
        input  ctrl_d, rd1_d, rd2_d, pc_d, pcplus4_d, immext_d, funct3_d,
               rs1_d, rs2_d, rd_d, valid_d,
        output ctrl_e, rd1_e, rd2_e, pc_e, pcplus4_e, immext_e, funct3_e,
               rs1_e, rs2_e, rd_e, valid_e
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use / control-hazard logic for the D/E boundary.
// Inputs : ctrl_e, rd_e (instruction in E), rs1_d, rs2_d, valid_d (instruction in D),
//          pcsrc_e (taken branch/jump in E), stall_e (external E hold)
// Outputs: lw_stall (load-use detected), stall_f/stall_d (hold PC and IF/ID),
//          flush_d (clear IF/ID), flush_e (insert bubble into E)
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int RADDR_W = 5
) (
    input  ctrl_t              ctrl_e,
    input  logic [RADDR_W-1:0] rd_e,
    input  logic [RADDR_W-1:0] rs1_d,
    input  logic [RADDR_W-1:0] rs2_d,
    input  logic               valid_d,
    input  logic               pcsrc_e,
    input  logic               stall_e,
    output logic               lw_stall,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_d,
    output logic               flush_e
);

    logic load_in_e;
    logic unused_ctrl;

    // Stores also select RES_MEM but never write a register, so RegWrite
    // is what separates a load from a store here.
    assign load_in_e = ctrl_e.RegWrite && (ctrl_e.ResultSrc == RES_MEM);

    // x0 is never a real dependency.
    assign lw_stall  = load_in_e && (rd_e != '0) && valid_d &&
                       ((rd_e == rs1_d) || (rd_e == rs2_d));

    assign stall_f   = lw_stall | stall_e;
    assign stall_d   = lw_stall | stall_e;
    assign flush_d   = pcsrc_e & ~stall_e;
    assign flush_e   = (lw_stall | pcsrc_e) & ~stall_e;

    assign unused_ctrl = ^{ctrl_e.MemWrite, ctrl_e.Jump, ctrl_e.Branch,
                           ctrl_e.ALUControl, ctrl_e.ALUSrc, ctrl_e.JalrmuxSel};

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated hazard control.
// Optional feature macro: ID_EX_PERF_CNT_EN (adds bubble_cnt / flush_cnt).
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous, active-low reset
//   bus        : id_ex_stage_if.slave -- *_d in, registered *_e out
//   pcsrc_e    : taken branch/jump resolved in E
//   stall_e    : external E hold (data memory wait)
//   stall_f    : hold PC
//   stall_d    : hold IF/ID
//   flush_d    : clear IF/ID
//   bubble_cnt : load-use bubbles inserted   (ID_EX_PERF_CNT_EN only)
//   flush_cnt  : taken-branch flushes        (ID_EX_PERF_CNT_EN only)
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RADDR_W    = 5
`ifdef ID_EX_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic           clk,
    input  logic           rst,
    id_ex_stage_if.slave   bus,
    input  logic           pcsrc_e,
    input  logic           stall_e,
    output logic           stall_f,
    output logic           stall_d,
    output logic           flush_d
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    logic                  lw_stall;
    logic                  flush_e;

    ctrl_t                 ctrl_p1;
    logic [DATA_WIDTH-1:0] rd1_p1;
    logic [DATA_WIDTH-1:0] rd2_p1;
    logic [DATA_WIDTH-1:0] pc_p1;
    logic [DATA_WIDTH-1:0] pcplus4_p1;
    logic [DATA_WIDTH-1:0] immext_p1;
    logic [2:0]            funct3_p1;
    logic [RADDR_W-1:0]    rs1_p1;
    logic [RADDR_W-1:0]    rs2_p1;
    logic [RADDR_W-1:0]    rd_p1;
    logic                  vld_p1;

    hazard_detect #(.RADDR_W(RADDR_W)) u_hazard (
        .ctrl_e   (ctrl_p1),
        .rd_e     (rd_p1),
        .rs1_d    (bus.rs1_d),
        .rs2_d    (bus.rs2_d),
        .valid_d  (bus.valid_d),
        .pcsrc_e  (pcsrc_e),
        .stall_e  (stall_e),
        .lw_stall (lw_stall),
        .stall_f  (stall_f),
        .stall_d  (stall_d),
        .flush_d  (flush_d),
        .flush_e  (flush_e)
    );

    // ---- D -> E boundary: hold on stall_e, bubble on flush_e, else capture.
    // Bubbles zero every field so rd_e=0 and nothing forwards from them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_p1    <= CTRL_NOP;
            rd1_p1     <= '0;
            rd2_p1     <= '0;
            pc_p1      <= '0;
            pcplus4_p1 <= '0;
            immext_p1  <= '0;
            funct3_p1  <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            rd_p1      <= '0;
            vld_p1     <= 1'b0;
        end else if (!stall_e) begin
            if (flush_e) begin
                ctrl_p1    <= CTRL_NOP;
                rd1_p1     <= '0;
                rd2_p1     <= '0;
                pc_p1      <= '0;
                pcplus4_p1 <= '0;
                immext_p1  <= '0;
                funct3_p1  <= '0;
                rs1_p1     <= '0;
                rs2_p1     <= '0;
                rd_p1      <= '0;
                vld_p1     <= 1'b0;
            end else begin
                ctrl_p1    <= bus.ctrl_d;
                rd1_p1     <= bus.rd1_d;
                rd2_p1     <= bus.rd2_d;
                pc_p1      <= bus.pc_d;
                pcplus4_p1 <= bus.pcplus4_d;
                immext_p1  <= bus.immext_d;
                funct3_p1  <= bus.funct3_d;
                rs1_p1     <= bus.rs1_d;
                rs2_p1     <= bus.rs2_d;
                rd_p1      <= bus.rd_d;
                vld_p1     <= bus.valid_d;
            end
        end
    end

    assign bus.ctrl_e    = ctrl_p1;
    assign bus.rd1_e     = rd1_p1;
    assign bus.rd2_e     = rd2_p1;
    assign bus.pc_e      = pc_p1;
    assign bus.pcplus4_e = pcplus4_p1;
    assign bus.immext_e  = immext_p1;
    assign bus.funct3_e  = funct3_p1;
    assign bus.rs1_e     = rs1_p1;
    assign bus.rs2_e     = rs2_p1;
    assign bus.rd_e      = rd_p1;
    assign bus.valid_e   = vld_p1;

`ifdef ID_EX_PERF_CNT_EN
    // Counters wrap naturally; both freeze while stall_e holds the stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (lw_stall && !stall_e) bubble_cnt <= bubble_cnt + 1'b1;
            if (pcsrc_e && !stall_e)  flush_cnt  <= flush_cnt + 1'b1;
        end
    end
`else
    logic unused_lw_stall;
    assign unused_lw_stall = lw_stall;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    import pipeline_pkg::*;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        valid;
    } slot_t;

    logic clk = 1'b0;
    logic rst;
    logic pcsrc_e, stall_e;
    logic stall_f, stall_d, flush_d;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference: the instruction currently occupying the execute slot,
    // plus how many bubbles / flushes the rules say have happened.
    slot_t  m_e;
    int     m_bub;
    int     m_fl;

    id_ex_stage_if #(.DATA_WIDTH(32), .RADDR_W(5)) bus ();

    id_ex_stage dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .pcsrc_e (pcsrc_e),
        .stall_e (stall_e),
        .stall_f (stall_f),
        .stall_d (stall_d),
        .flush_d (flush_d)
`ifdef ID_EX_PERF_CNT_EN
        ,
        .bubble_cnt (bubble_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic rw, input logic [1:0] rsrc, input logic mw,
                                 input logic asrc, input logic [31:0] imm);
        slot_t s;
        s.ctrl            = '0;
        s.ctrl.RegWrite   = rw;
        s.ctrl.ResultSrc  = rsrc;
        s.ctrl.MemWrite   = mw;
        s.ctrl.ALUSrc     = asrc;
        s.ctrl.ALUControl = 3'($urandom_range(0, 7));
        s.rd1 = $urandom; s.rd2 = $urandom;
        s.pc  = $urandom & 32'hFFFF_FFFC;
        s.pc4 = s.pc + 32'd4;
        s.imm = imm;
        s.f3  = 3'($urandom_range(0, 7));
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.valid = 1'b1;
        return s;
    endfunction

    function automatic slot_t rnd_slot();
        slot_t s;
        s      = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom);
        s.ctrl = ctrl_t'($urandom);
        s.valid = ($urandom_range(0, 9) != 0);
        return s;
    endfunction

    // A load in E (writes a register from memory) that targets a non-zero
    // register read by a real instruction in D.
    function automatic logic load_use(input slot_t d);
        logic is_load;
        is_load = m_e.ctrl.RegWrite && (m_e.ctrl.ResultSrc == 2'b01);
        return is_load && (m_e.rd != 5'd0) && d.valid && ((m_e.rd == d.rs1) || (m_e.rd == d.rs2));
    endfunction

    task automatic apply(input slot_t d);
        bus.ctrl_d = d.ctrl;  bus.rd1_d = d.rd1;  bus.rd2_d = d.rd2;
        bus.pc_d = d.pc;      bus.pcplus4_d = d.pc4;  bus.immext_d = d.imm;
        bus.funct3_d = d.f3;  bus.rs1_d = d.rs1;  bus.rs2_d = d.rs2;
        bus.rd_d = d.rd;      bus.valid_d = d.valid;
    endtask

    task automatic check_e();
        check("ctrl_e",    bus.ctrl_e,    m_e.ctrl);
        check("rd1_e",     bus.rd1_e,     m_e.rd1);
        check("rd2_e",     bus.rd2_e,     m_e.rd2);
        check("pc_e",      bus.pc_e,      m_e.pc);
        check("pcplus4_e", bus.pcplus4_e, m_e.pc4);
        check("immext_e",  bus.immext_e,  m_e.imm);
        check("funct3_e",  bus.funct3_e,  m_e.f3);
        check("rs1_e",     bus.rs1_e,     m_e.rs1);
        check("rs2_e",     bus.rs2_e,     m_e.rs2);
        check("rd_e",      bus.rd_e,      m_e.rd);
        check("valid_e",   bus.valid_e,   m_e.valid);
`ifdef ID_EX_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt, 64'(m_bub));
        check("flush_cnt",  flush_cnt,  64'(m_fl));
`endif
    endtask

    // One clock: drive D, check the combinational hazard outputs, clock,
    // advance the reference, check the E slot.
    task automatic cycle(input slot_t d, input logic pc, input logic se);
        logic lw;
        apply(d);
        pcsrc_e = pc;
        stall_e = se;
        #2;
        lw = load_use(d);
        check("stall_f", stall_f, lw | se);
        check("stall_d", stall_d, lw | se);
        check("flush_d", flush_d, pc & ~se);
        @(posedge clk);
        if (!se) begin
            if (lw) m_bub++;
            if (pc) m_fl++;
            m_e = (lw || pc) ? slot_t'('0) : d;
        end
        #1;
        check_e();
    endtask

    initial begin
        slot_t a, b, held;
        m_e = '0; m_bub = 0; m_fl = 0;
        rst = 1'b0; pcsrc_e = 1'b0; stall_e = 1'b0;
        apply(mk(5'd3, 5'd1, 5'd2, 1'b1, 2'b01, 1'b0, 1'b0, 32'd9));

        // Reset state
        #3;
        check_e();
        check("rst_stall_f", stall_f, 1'b0);
        check("rst_flush_d", flush_d, 1'b0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        // Pass-through: addi x5, imm 7
        a = mk(5'd5, 5'd1, 5'd0, 1'b1, 2'b00, 1'b0, 1'b1, 32'd7);
        cycle(a, 1'b0, 1'b0);
        check("addi_rd_e", bus.rd_e, 5'd5);
        check("addi_imm_e", bus.immext_e, 32'd7);
        check("addi_valid_e", bus.valid_e, 1'b1);

        // Load-use: lw x6 then add reading x6 -> one bubble, then the add
        cycle(mk(5'd6, 5'd2, 5'd0, 1'b1, 2'b01, 1'b0, 1'b1, 32'd4), 1'b0, 1'b0);
        b = mk(5'd9, 5'd6, 5'd3, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0);
        cycle(b, 1'b0, 1'b0);
        check("lu_bubble_valid", bus.valid_e, 1'b0);
        check("lu_bubble_ctrl", bus.ctrl_e, 11'd0);
        cycle(b, 1'b0, 1'b0);
        check("lu_add_rd", bus.rd_e, 5'd9);
        check("lu_add_valid", bus.valid_e, 1'b1);

        // Store in E is not a load
        cycle(mk(5'd6, 5'd1, 5'd2, 1'b0, 2'b01, 1'b1, 1'b1, 32'd8), 1'b0, 1'b0);
        cycle(mk(5'd4, 5'd6, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0), 1'b0, 1'b0);
        check("sw_no_stall_valid", bus.valid_e, 1'b1);
        // lw x0 never stalls
        cycle(mk(5'd0, 5'd1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b1, 32'd0), 1'b0, 1'b0);
        cycle(mk(5'd4, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0), 1'b0, 1'b0);
        check("x0_no_stall_valid", bus.valid_e, 1'b1);

        // Taken branch flushes E
        cycle(mk(5'd2, 5'd1, 5'd1, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0), 1'b1, 1'b0);
        check("br_valid_e", bus.valid_e, 1'b0);
        // Load-use together with a taken branch: still a single bubble
        cycle(mk(5'd7, 5'd1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b1, 32'd0), 1'b0, 1'b0);
        cycle(mk(5'd3, 5'd7, 5'd0, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0), 1'b1, 1'b0);
        check("br_lu_valid_e", bus.valid_e, 1'b0);

        // External stall with branch and load-use pending: E holds
        held = mk(5'd8, 5'd1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b1, 32'd12);
        cycle(held, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(mk(5'd1, 5'd2, 5'd8, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0), 1'b1, 1'b1);
            check("hold_rd_e", bus.rd_e, 5'd8);
            check("hold_imm_e", bus.immext_e, 32'd12);
        end
        cycle(mk(5'd1, 5'd2, 5'd8, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0), 1'b0, 1'b0);

        // Asynchronous reset mid-run, between edges
        cycle(mk(5'd6, 5'd1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 32'd0), 1'b0, 1'b0);
        apply(mk(5'd2, 5'd6, 5'd6, 1'b1, 2'b00, 1'b0, 1'b0, 32'd0));
        pcsrc_e = 1'b0; stall_e = 1'b0;
        rst = 1'b0;
        #1;
        m_e = '0; m_bub = 0; m_fl = 0;
        check("mid_rst_valid_e", bus.valid_e, 1'b0);
        check("mid_rst_ctrl_e", bus.ctrl_e, 11'd0);
        check("mid_rst_rd_e", bus.rd_e, 5'd0);
        check("mid_rst_stall_f", stall_f, 1'b0);
        check_e();
        stall_e = 1'b1;
        #1;
        check("mid_rst_stall_e", stall_f, 1'b1);
        stall_e = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the reference
        for (int n = 0; n < 400; n++) begin
            cycle(rnd_slot(), ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
